// File: rtl/qdr_arb_pkg.sv
// Shared constants and types for the QDR-II+ two-requester arbiter.
package qdr_arb_pkg;
  localparam int NUM_REQ       = 2;
  localparam int ADDR_W_DEF    = 18;
  localparam int DATA_W_DEF    = 144;
  localparam int BW_W_DEF      = 16;
  localparam int TAG_DEPTH_DEF = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;
endpackage

// File: rtl/qdr_arb_rr.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module qdr_arb_rr
  import qdr_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  req_id_t last_gnt;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == REQ1) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  // Reset points at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= REQ1;
    end else if (|gnt) begin
      last_gnt <= gnt[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/qdr_arb.sv
// Two-requester arbiter in front of a MIG QDR-II+ user interface, with an
// in-order tag FIFO that routes read returns back to the issuing requester.
module qdr_arb
  import qdr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int BW_WIDTH   = BW_W_DEF,
  parameter int TAG_DEPTH  = TAG_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cal_done,
  input  logic [1:0]              wr_req,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic [2*BW_WIDTH-1:0]   wr_bw_n,
  output logic [1:0]              wr_ack,
  input  logic [1:0]              rd_req,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]              rd_ack,
  output logic [1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    app_wr_cmd,
  output logic [ADDR_WIDTH-1:0]   app_wr_addr,
  output logic [DATA_WIDTH-1:0]   app_wr_data,
  output logic [BW_WIDTH-1:0]     app_wr_bw_n,
  output logic                    app_rd_cmd,
  output logic [ADDR_WIDTH-1:0]   app_rd_addr,
  input  logic                    app_rd_valid,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    err_unexp
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  logic [NUM_REQ-1:0] wr_gnt_p0, rd_gnt_p0;
  logic               tag_push_p0, tag_pop_p0, rd_room_p0;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]      tag_wr_ptr, tag_rd_ptr;
  logic [CW-1:0]      out_cnt;

  // A pop in the same cycle frees a slot, so a full FIFO may still grant.
  assign tag_pop_p0  = app_rd_valid && (out_cnt != '0);
  assign rd_room_p0  = (out_cnt < DEPTH_C) || tag_pop_p0;
  assign tag_push_p0 = |rd_gnt_p0;

  qdr_arb_rr u_wr_rr (
    .clk (clk),
    .rst (rst),
    .en  (cal_done && !rst),
    .req (wr_req),
    .gnt (wr_gnt_p0)
  );

  qdr_arb_rr u_rd_rr (
    .clk (clk),
    .rst (rst),
    .en  (cal_done && !rst && rd_room_p0),
    .req (rd_req),
    .gnt (rd_gnt_p0)
  );

  assign wr_ack = wr_gnt_p0;
  assign rd_ack = rd_gnt_p0;

  // ---- p0 -> p1: accepted commands registered onto the MIG interface ----
  always_ff @(posedge clk) begin
    if (rst) begin
      app_wr_cmd  <= 1'b0;
      app_wr_addr <= '0;
      app_wr_data <= '0;
      app_wr_bw_n <= '1;
      app_rd_cmd  <= 1'b0;
      app_rd_addr <= '0;
    end else begin
      app_wr_cmd <= |wr_gnt_p0;
      app_rd_cmd <= |rd_gnt_p0;
      if (|wr_gnt_p0) begin
        app_wr_addr <= wr_gnt_p0[1] ? wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : wr_addr[ADDR_WIDTH-1:0];
        app_wr_data <= wr_gnt_p0[1] ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : wr_data[DATA_WIDTH-1:0];
        app_wr_bw_n <= wr_gnt_p0[1] ? wr_bw_n[2*BW_WIDTH-1:BW_WIDTH]     : wr_bw_n[BW_WIDTH-1:0];
      end
      if (|rd_gnt_p0) begin
        app_rd_addr <= rd_gnt_p0[1] ? rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push_p0) begin
      tag_mem[tag_wr_ptr] <= rd_gnt_p0[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      out_cnt    <= '0;
      err_unexp  <= 1'b0;
    end else begin
      if (tag_push_p0) tag_wr_ptr <= tag_wr_ptr + PW'(1);
      if (tag_pop_p0)  tag_rd_ptr <= tag_rd_ptr + PW'(1);
      case ({tag_push_p0, tag_pop_p0})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (app_rd_valid && (out_cnt == '0)) err_unexp <= 1'b1;
    end
  end

  // ---- p0 -> p1: read return routed by the oldest tag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (tag_pop_p0) begin
        rd_valid <= tag_mem[tag_rd_ptr] ? 2'b10 : 2'b01;
        rd_data  <= app_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_qdr_arb.sv
// Bench for qdr_arb: table-driven arbitration vectors plus scoreboarded
// command/return sequences for the FIFO-full, return routing and reset cases.
module tb_qdr_arb;
  localparam int AW = 18;
  localparam int DW = 144;
  localparam int BW = 16;

  logic            clk, rst, cal_done;
  logic [1:0]      wr_req, rd_req, wr_ack, rd_ack, rd_valid;
  logic [2*AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*BW-1:0] wr_bw_n;
  logic [DW-1:0]   rd_data, app_wr_data, app_rd_data;
  logic            app_wr_cmd, app_rd_cmd, app_rd_valid, err_unexp;
  logic [AW-1:0]   app_wr_addr, app_rd_addr;
  logic [BW-1:0]   app_wr_bw_n;

  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];

  typedef struct {
    logic       cal;
    logic [1:0] wreq;
    logic [1:0] rreq;
    logic [1:0] ewack;
    logic [1:0] erack;
  } vec_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bw;
  } wexp_t;
  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
  } ret_t;

  vec_t          tbl [8];
  wexp_t         wq [$];
  logic [AW-1:0] rq [$];
  ret_t          retq [$];

  logic          exp_wcmd, exp_rcmd;
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rdata, last_rdata;
  int            n_chk, n_err;

  function automatic logic [DW-1:0] mkw(input logic [AW-1:0] a);
    return {8{a}};
  endfunction
  function automatic logic [DW-1:0] mkr(input logic [AW-1:0] a);
    return ~{8{a}};
  endfunction
  function automatic logic [BW-1:0] bwv(input logic [AW-1:0] a);
    return a[BW-1:0] ^ 16'hF0F0;
  endfunction

  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {mkw(wa[1]), mkw(wa[0])};
  assign wr_bw_n = {bwv(wa[1]), bwv(wa[0])};
  assign rd_addr = {ra[1], ra[0]};

  qdr_arb dut (
    .clk          (clk),
    .rst          (rst),
    .cal_done     (cal_done),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_bw_n      (wr_bw_n),
    .wr_ack       (wr_ack),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .app_wr_cmd   (app_wr_cmd),
    .app_wr_addr  (app_wr_addr),
    .app_wr_data  (app_wr_data),
    .app_wr_bw_n  (app_wr_bw_n),
    .app_rd_cmd   (app_rd_cmd),
    .app_rd_addr  (app_rd_addr),
    .app_rd_valid (app_rd_valid),
    .app_rd_data  (app_rd_data),
    .err_unexp    (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Advance one clock and compare the registered outputs against the scoreboard.
  task automatic tick();
    wexp_t w;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    chk("app_wr_cmd", 160'(app_wr_cmd), 160'(exp_wcmd));
    if (exp_wcmd && wq.size() > 0) begin
      w = wq.pop_front();
      chk("app_wr_addr", 160'(app_wr_addr), 160'(w.addr));
      chk("app_wr_data", 160'(app_wr_data), 160'(w.data));
      chk("app_wr_bw_n", 160'(app_wr_bw_n), 160'(w.bw));
    end
    chk("app_rd_cmd", 160'(app_rd_cmd), 160'(exp_rcmd));
    if (exp_rcmd && rq.size() > 0) begin
      a = rq.pop_front();
      chk("app_rd_addr", 160'(app_rd_addr), 160'(a));
    end
    chk("rd_valid", 160'(rd_valid), 160'(exp_rv));
    if (exp_rv != 2'b00) last_rdata = exp_rdata;
    chk("rd_data", 160'(rd_data), 160'(last_rdata));
    exp_wcmd = 1'b0;
    exp_rcmd = 1'b0;
    exp_rv   = 2'b00;
  endtask

  // Drive one cycle of requests (and optionally a MIG return), check the
  // combinational acks, and queue what should appear one cycle later.
  task automatic apply(input logic cal, input logic [1:0] wreq, input logic [1:0] rreq,
                       input logic [1:0] ewack, input logic [1:0] erack, input logic rdv);
    ret_t  r;
    wexp_t w;
    cal_done     = cal;
    wr_req       = wreq;
    rd_req       = rreq;
    app_rd_valid = rdv;
    app_rd_data  = {DW{1'b1}};
    exp_wcmd     = 1'b0;
    exp_rcmd     = 1'b0;
    exp_rv       = 2'b00;
    if (rdv && retq.size() > 0) begin
      r           = retq.pop_front();
      app_rd_data = mkr(r.addr);
      exp_rv      = r.id ? 2'b10 : 2'b01;
      exp_rdata   = mkr(r.addr);
    end
    #1;
    chk("wr_ack", 160'(wr_ack), 160'(ewack));
    chk("rd_ack", 160'(rd_ack), 160'(erack));
    if (ewack != 2'b00) begin
      exp_wcmd = 1'b1;
      w.addr   = ewack[1] ? wa[1] : wa[0];
      w.data   = mkw(w.addr);
      w.bw     = bwv(w.addr);
      wq.push_back(w);
    end
    if (erack != 2'b00) begin
      exp_rcmd = 1'b1;
      r.id     = erack[1];
      r.addr   = erack[1] ? ra[1] : ra[0];
      rq.push_back(r.addr);
      retq.push_back(r);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cal_done = 1'b0;
    wr_req = 2'b00;
    rd_req = 2'b00;
    app_rd_valid = 1'b0;
    wq.delete();
    rq.delete();
    retq.delete();
    last_rdata = '0;
    exp_wcmd = 1'b0;
    exp_rcmd = 1'b0;
    exp_rv = 2'b00;
    tick();
    chk("rst_app_wr_bw_n", 160'(app_wr_bw_n), 160'({BW{1'b1}}));
    chk("rst_app_wr_addr", 160'(app_wr_addr), 160'(0));
    chk("rst_app_wr_data", 160'(app_wr_data), 160'(0));
    chk("rst_app_rd_addr", 160'(app_rd_addr), 160'(0));
    chk("rst_err_unexp", 160'(err_unexp), 160'(0));
    chk("rst_wr_ack", 160'(wr_ack), 160'(0));
    chk("rst_rd_ack", 160'(rd_ack), 160'(0));
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    wa[0] = '0; wa[1] = '0; ra[0] = '0; ra[1] = '0;
    app_rd_data = '0;
    tbl[0] = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b00};
    tbl[1] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b00};
    tbl[2] = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b00};
    tbl[3] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b00};
    tbl[4] = '{1'b1, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[5] = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00};
    tbl[6] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};

    do_reset();
    tick();

    // No acceptance before calibration completes.
    wa[0] = 18'h00aa; wa[1] = 18'h00bb;
    for (int i = 0; i < 10; i++) apply(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);

    // Write round-robin from reset state, then single-requester and idle rows.
    for (int i = 0; i < 8; i++) begin
      wa[0] = 18'h100 + 18'(i);
      wa[1] = 18'h200 + 18'(i);
      apply(tbl[i].cal, tbl[i].wreq, tbl[i].rreq, tbl[i].ewack, tbl[i].erack, 1'b0);
    end

    // Fill the tag FIFO from requester 1; the 17th read waits for a pop.
    for (int i = 0; i < 16; i++) begin
      ra[1] = 18'h300 + 18'(i);
      apply(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    end
    ra[1] = 18'h3ff;
    apply(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    apply(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1);
    for (int i = 0; i < 16; i++) apply(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    // Interleaved reads, one alongside a write, then a read contention.
    wa[0] = 18'h0777;
    ra[0] = 18'h10;
    apply(1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
    ra[1] = 18'h20;
    apply(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    ra[0] = 18'h30;
    apply(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0);
    ra[0] = 18'h31; ra[1] = 18'h40;
    apply(1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 1'b0);
    // Calibration drops: no new grants, returns still routed.
    for (int i = 0; i < 4; i++) apply(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
    apply(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("err_before_unexp", 160'(err_unexp), 160'(0));

    // Unexpected return: dropped, sticky error.
    apply(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("err_sticky", 160'(err_unexp), 160'(1));
      apply(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    end

    // Reset with three reads in flight; late return then flags an error.
    ra[0] = 18'h50; ra[1] = 18'h60;
    apply(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0);
    apply(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    apply(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0);
    do_reset();
    apply(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("err_late_return", 160'(err_unexp), 160'(1));
    wa[0] = 18'h0a0; wa[1] = 18'h0b0; ra[0] = 18'h0c0; ra[1] = 18'h0d0;
    apply(1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0);
    apply(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
